conv_sequencer: RTL and testbench

Control FSM for the systolic-array convolution accelerator. It latches one layer's configuration on EN and walks the convolution loop nest. Each step it issues one beat to the array datapath: input SRAM address, weight SRAM address, padding flag, accumulate first/last flags and output address. It reports progress on STATE, which the bench polls to decide when to dump output memory.

---
 rtl/conv_pkg.sv | 42 ++++
 rtl/conv_addr_gen.sv | 51 +++++
 rtl/conv_sequencer.sv | 173 +++++++++++++++++
 tb/tb_conv_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared encodings and field positions for the convolution sequencer
package conv_pkg;

  localparam int ADDR_W_DEF    = 13;
  localparam int ARRAY_DIM_DEF = 8;

  localparam int ISIZE_H_MSB  = 15;
  localparam int ISIZE_H_LSB  = 8;
  localparam int ISIZE_W_MSB  = 7;
  localparam int ISIZE_W_LSB  = 0;
  localparam int WSIZE_KH_MSB = 7;
  localparam int WSIZE_KH_LSB = 4;
  localparam int WSIZE_KW_MSB = 3;
  localparam int WSIZE_KW_LSB = 0;

  localparam logic [5:0] ST_IDLE  = 6'd0;
  localparam logic [5:0] ST_RUN   = 6'd1;
  localparam logic [5:0] ST_DRAIN = 6'd2;
  localparam logic [5:0] ST_DONE  = 6'd3;
  localparam logic [5:0] ST_ERR   = 6'd4;

  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_CHECK,
    FSM_RUN,
    FSM_DRAIN,
    FSM_DONE,
    FSM_ERR
  } fsm_e;

  // The legality-check cycle is reported as RUN: the layer has been accepted for processing.
  function automatic logic [5:0] state_code(input fsm_e s);
    case (s)
      FSM_CHECK, FSM_RUN: state_code = ST_RUN;
      FSM_DRAIN:          state_code = ST_DRAIN;
      FSM_DONE:           state_code = ST_DONE;
      FSM_ERR:            state_code = ST_ERR;
      default:            state_code = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - combinational input/weight/output address and padding computation
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [10:0]       i_oy_org,
  input  logic [10:0]       i_ox_org,
  input  logic [3:0]        i_ky,
  input  logic [3:0]        i_kx,
  input  logic [9:0]        i_ic,
  input  logic [9:0]        i_tile,
  input  logic [ADDR_W-1:0] i_ocnt,
  input  logic [7:0]        i_h,
  input  logic [7:0]        i_w,
  input  logic [5:0]        i_p,
  input  logic [3:0]        i_kh,
  input  logic [3:0]        i_kw,
  input  logic [9:0]        i_nin,
  input  logic [ADDR_W-1:0] i_iaddr,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [ADDR_W-1:0] i_oaddr,
  output logic [ADDR_W-1:0] o_iaddr,
  output logic              o_ipad,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [ADDR_W-1:0] o_oaddr
);

  logic signed [12:0] w_iy;
  logic signed [12:0] w_ix;
  logic [31:0]        w_ipix;
  logic [31:0]        w_ioff;
  logic [31:0]        w_woff;

  assign w_iy = $signed({2'b0, i_oy_org}) + $signed({9'b0, i_ky}) - $signed({7'b0, i_p});
  assign w_ix = $signed({2'b0, i_ox_org}) + $signed({9'b0, i_kx}) - $signed({7'b0, i_p});

  assign o_ipad = w_iy[12] || w_ix[12] ||
                  (w_iy >= $signed({5'b0, i_h})) || (w_ix >= $signed({5'b0, i_w}));

  // Offsets are formed wide and truncated once at the final base-address sum.
  assign w_ipix = 32'(w_iy[11:0]) * 32'(i_w) + 32'(w_ix[11:0]);
  assign w_ioff = w_ipix * 32'(i_nin) + 32'(i_ic);
  assign w_woff = ((32'(i_tile) * 32'(i_kh) + 32'(i_ky)) * 32'(i_kw) + 32'(i_kx))
                  * 32'(i_nin) + 32'(i_ic);

  assign o_iaddr = o_ipad ? '0 : i_iaddr + w_ioff[ADDR_W-1:0];
  assign o_waddr = i_waddr + w_woff[ADDR_W-1:0];
  assign o_oaddr = i_oaddr + i_ocnt;

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - layer config latch, legality check and convolution loop-nest FSM
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int ARRAY_DIM = ARRAY_DIM_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic [9:0]        NIN,
  input  logic [9:0]        NOUT,
  input  logic [15:0]       ISIZE,
  input  logic [5:0]        IPADDING,
  input  logic [7:0]        WSIZE,
  input  logic [3:0]        WSTRIDE,
  input  logic [5:0]        OSHIFT,
  input  logic [ADDR_W-1:0] IADDR,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [ADDR_W-1:0] OADDR,
  output logic [5:0]        STATE,
  output logic              S_VALID,
  input  logic              S_READY,
  output logic [ADDR_W-1:0] S_IADDR,
  output logic              S_IPAD,
  output logic [ADDR_W-1:0] S_WADDR,
  output logic              S_FIRST,
  output logic              S_LAST,
  output logic [ADDR_W-1:0] S_OADDR,
  output logic [5:0]        S_OSHIFT,
  input  logic              ARRAY_IDLE
);

  fsm_e r_state, w_next;

  logic [9:0]        r_nin, r_nout;
  logic [7:0]        r_h, r_w;
  logic [5:0]        r_p, r_oshift;
  logic [3:0]        r_kh, r_kw, r_s;
  logic [ADDR_W-1:0] r_iaddr, r_waddr, r_oaddr;

  logic [9:0]        r_oc_base, r_tile, r_ic;
  logic [10:0]       r_oy_org, r_ox_org;
  logic [3:0]        r_ky, r_kx;
  logic [ADDR_W-1:0] r_ocnt;

  logic [10:0]       w_hp, w_wp;
  logic              w_run, w_xfer, w_illegal;
  logic              w_ic_last, w_kx_last, w_ky_last, w_ox_last, w_oy_last, w_tile_last;
  logic [ADDR_W-1:0] w_iaddr, w_waddr, w_oaddr;
  logic              w_ipad;

  assign w_hp = 11'(r_h) + 11'({r_p, 1'b0});
  assign w_wp = 11'(r_w) + 11'({r_p, 1'b0});

  assign w_illegal = (r_kh == 4'd0) || (r_kw == 4'd0) || (r_s == 4'd0) ||
                     (r_nin == 10'd0) || (r_nout == 10'd0) || (r_h == 8'd0) || (r_w == 8'd0) ||
                     (11'(r_kh) > w_hp) || (11'(r_kw) > w_wp);

  assign w_ic_last   = (r_ic == r_nin - 10'd1);
  assign w_kx_last   = (r_kx == r_kw - 4'd1);
  assign w_ky_last   = (r_ky == r_kh - 4'd1);
  assign w_ox_last   = (12'(r_ox_org) + 12'(r_s) + 12'(r_kw)) > 12'(w_wp);
  assign w_oy_last   = (12'(r_oy_org) + 12'(r_s) + 12'(r_kh)) > 12'(w_hp);
  assign w_tile_last = (11'(r_oc_base) + 11'(ARRAY_DIM)) >= 11'(r_nout);

  assign w_run  = (r_state == FSM_RUN);
  assign w_xfer = w_run && S_READY;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= FSM_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FSM_IDLE:  if (EN) w_next = FSM_CHECK;
      FSM_CHECK: w_next = w_illegal ? FSM_ERR : FSM_RUN;
      FSM_RUN:   if (w_xfer && w_ic_last && w_kx_last && w_ky_last &&
                     w_ox_last && w_oy_last && w_tile_last) w_next = FSM_DRAIN;
      FSM_DRAIN: if (ARRAY_IDLE) w_next = FSM_DONE;
      FSM_DONE, FSM_ERR: if (!EN) w_next = FSM_IDLE;
      default:   w_next = FSM_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_nin <= '0; r_nout <= '0; r_h <= '0; r_w <= '0; r_p <= '0; r_oshift <= '0;
      r_kh <= '0; r_kw <= '0; r_s <= '0; r_iaddr <= '0; r_waddr <= '0; r_oaddr <= '0;
    end else if (r_state == FSM_IDLE && EN) begin
      r_nin    <= NIN;
      r_nout   <= NOUT;
      r_h      <= ISIZE[ISIZE_H_MSB:ISIZE_H_LSB];
      r_w      <= ISIZE[ISIZE_W_MSB:ISIZE_W_LSB];
      r_p      <= IPADDING;
      r_kh     <= WSIZE[WSIZE_KH_MSB:WSIZE_KH_LSB];
      r_kw     <= WSIZE[WSIZE_KW_MSB:WSIZE_KW_LSB];
      r_s      <= WSTRIDE;
      r_oshift <= OSHIFT;
      r_iaddr  <= IADDR;
      r_waddr  <= WADDR;
      r_oaddr  <= OADDR;
    end
  end

  // Odometer over (tile, oy, ox, ky, kx, ic); origins step by stride so no multiply is needed.
  always_ff @(posedge CLK) begin
    if (RESET || r_state == FSM_IDLE) begin
      r_oc_base <= '0; r_tile <= '0; r_oy_org <= '0; r_ox_org <= '0;
      r_ky <= '0; r_kx <= '0; r_ic <= '0; r_ocnt <= '0;
    end else if (w_xfer) begin
      if (!w_ic_last) r_ic <= r_ic + 10'd1;
      else begin
        r_ic <= '0;
        if (!w_kx_last) r_kx <= r_kx + 4'd1;
        else begin
          r_kx <= '0;
          if (!w_ky_last) r_ky <= r_ky + 4'd1;
          else begin
            r_ky   <= '0;
            r_ocnt <= r_ocnt + 1'b1;
            if (!w_ox_last) r_ox_org <= r_ox_org + 11'(r_s);
            else begin
              r_ox_org <= '0;
              if (!w_oy_last) r_oy_org <= r_oy_org + 11'(r_s);
              else begin
                r_oy_org  <= '0;
                r_oc_base <= r_oc_base + 10'(ARRAY_DIM);
                r_tile    <= r_tile + 10'd1;
              end
            end
          end
        end
      end
    end
  end

  conv_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_oy_org (r_oy_org),
    .i_ox_org (r_ox_org),
    .i_ky     (r_ky),
    .i_kx     (r_kx),
    .i_ic     (r_ic),
    .i_tile   (r_tile),
    .i_ocnt   (r_ocnt),
    .i_h      (r_h),
    .i_w      (r_w),
    .i_p      (r_p),
    .i_kh     (r_kh),
    .i_kw     (r_kw),
    .i_nin    (r_nin),
    .i_iaddr  (r_iaddr),
    .i_waddr  (r_waddr),
    .i_oaddr  (r_oaddr),
    .o_iaddr  (w_iaddr),
    .o_ipad   (w_ipad),
    .o_waddr  (w_waddr),
    .o_oaddr  (w_oaddr)
  );

  assign STATE    = state_code(r_state);
  assign S_VALID  = w_run;
  assign S_IADDR  = w_run ? w_iaddr : '0;
  assign S_IPAD   = w_run && w_ipad;
  assign S_WADDR  = w_run ? w_waddr : '0;
  assign S_OADDR  = w_run ? w_oaddr : '0;
  assign S_FIRST  = w_run && (r_ic == 10'd0) && (r_kx == 4'd0) && (r_ky == 4'd0);
  assign S_LAST   = w_run && w_ic_last && w_kx_last && w_ky_last;
  assign S_OSHIFT = r_oshift;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - directed self-checking bench for conv_sequencer
module tb_conv_sequencer;

  logic        CLK, RESET, EN, S_READY, ARRAY_IDLE;
  logic [9:0]  NIN, NOUT;
  logic [15:0] ISIZE;
  logic [5:0]  IPADDING, OSHIFT;
  logic [7:0]  WSIZE;
  logic [3:0]  WSTRIDE;
  logic [12:0] IADDR, WADDR, OADDR;
  logic [5:0]  STATE, S_OSHIFT;
  logic        S_VALID, S_IPAD, S_FIRST, S_LAST;
  logic [12:0] S_IADDR, S_WADDR, S_OADDR;

  int errors = 0;
  int checks = 0;

  logic [12:0] q_iaddr[$], q_waddr[$], q_oaddr[$];
  bit          q_pad[$], q_first[$], q_last[$];
  logic [5:0]  st_seq[$];
  int          vcycles, unstable, end_cycles, first_valid;

  conv_sequencer dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .NIN(NIN), .NOUT(NOUT), .ISIZE(ISIZE),
    .IPADDING(IPADDING), .WSIZE(WSIZE), .WSTRIDE(WSTRIDE), .OSHIFT(OSHIFT),
    .IADDR(IADDR), .WADDR(WADDR), .OADDR(OADDR), .STATE(STATE), .S_VALID(S_VALID),
    .S_READY(S_READY), .S_IADDR(S_IADDR), .S_IPAD(S_IPAD), .S_WADDR(S_WADDR),
    .S_FIRST(S_FIRST), .S_LAST(S_LAST), .S_OADDR(S_OADDR), .S_OSHIFT(S_OSHIFT),
    .ARRAY_IDLE(ARRAY_IDLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [47:0] snap();
    return {S_IADDR, S_WADDR, S_OADDR, S_IPAD, S_FIRST, S_LAST, S_OSHIFT};
  endfunction

  task automatic set_cfg(input int h, input int w, input int k, input int s, input int p,
                         input int nin, input int nout);
    ISIZE    = {8'(h), 8'(w)};
    WSIZE    = {4'(k), 4'(k)};
    WSTRIDE  = 4'(s);
    IPADDING = 6'(p);
    NIN      = 10'(nin);
    NOUT     = 10'(nout);
    IADDR    = 13'h100;
    WADDR    = 13'h200;
    OADDR    = 13'h300;
    OSHIFT   = 6'h15;
  endtask

  task automatic run_layer(input bit rand_rdy, input bit stop_at_drain);
    logic [47:0] prev;
    logic [5:0]  last_st;
    bit          stalled, done;
    q_iaddr.delete(); q_waddr.delete(); q_oaddr.delete();
    q_pad.delete(); q_first.delete(); q_last.delete(); st_seq.delete();
    vcycles = 0; unstable = 0; end_cycles = -1; first_valid = -1;
    stalled = 0; done = 0; prev = '0; last_st = STATE;
    EN = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge CLK);
      if (stalled && snap() !== prev) unstable++;
      if (STATE !== last_st) begin
        st_seq.push_back(STATE);
        last_st = STATE;
      end
      if (STATE == 6'd3 || STATE == 6'd4 || (stop_at_drain && STATE == 6'd2)) begin
        done = 1;
        end_cycles = c + 1;
        break;
      end
      S_READY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (S_VALID) begin
        vcycles++;
        if (first_valid < 0) first_valid = c + 1;
      end
      if (S_VALID && S_READY) begin
        q_iaddr.push_back(S_IADDR); q_waddr.push_back(S_WADDR); q_oaddr.push_back(S_OADDR);
        q_pad.push_back(S_IPAD); q_first.push_back(S_FIRST); q_last.push_back(S_LAST);
      end
      stalled = S_VALID && !S_READY;
      prev = snap();
    end
    S_READY = 1'b1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL layer_timeout: state=%0d after cycle budget, want end state", STATE);
    end
  endtask

  task automatic end_layer(input string name);
    EN = 1'b0;
    @(negedge CLK);
    checks++;
    if (STATE !== 6'd0) begin
      errors++;
      $display("FAIL %s_idle: STATE=%0d want 0", name, STATE);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; EN = 1'b0; S_READY = 1'b1; ARRAY_IDLE = 1'b1;
    set_cfg(4, 4, 3, 1, 0, 1, 8);
    repeat (3) @(negedge CLK);
    checks++;
    if ({STATE, S_VALID, S_IADDR, S_WADDR, S_OADDR, S_IPAD, S_FIRST, S_LAST, S_OSHIFT} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: STATE=%0d VALID=%b IADDR=%h WADDR=%h OSHIFT=%h want all 0",
               STATE, S_VALID, S_IADDR, S_WADDR, S_OSHIFT);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    set_cfg(4, 4, 3, 1, 0, 1, 8);
    run_layer(0, 0);
    checks++; if (q_iaddr.size() != 36) begin errors++; $display("FAIL basic_count: got %0d want 36", q_iaddr.size()); end
    checks++; if (q_iaddr[0] !== 13'h100 || q_waddr[0] !== 13'h200 || q_first[0] !== 1'b1) begin
      errors++; $display("FAIL basic_beat0: iaddr=%h waddr=%h first=%b want 100 200 1", q_iaddr[0], q_waddr[0], q_first[0]); end
    checks++; if (q_iaddr[8] !== 13'h10A || q_waddr[8] !== 13'h208 || q_last[8] !== 1'b1 || q_oaddr[8] !== 13'h300) begin
      errors++; $display("FAIL basic_beat8: iaddr=%h waddr=%h last=%b oaddr=%h want 10a 208 1 300",
                         q_iaddr[8], q_waddr[8], q_last[8], q_oaddr[8]); end
    checks++; if (q_iaddr[9] !== 13'h101 || q_first[9] !== 1'b1 || q_last[7] !== 1'b0) begin
      errors++; $display("FAIL basic_beat9: iaddr=%h first=%b last7=%b want 101 1 0", q_iaddr[9], q_first[9], q_last[7]); end
    checks++; if (q_oaddr[35] !== 13'h303 || q_last[35] !== 1'b1) begin
      errors++; $display("FAIL basic_last_oaddr: got %h last=%b want 303 1", q_oaddr[35], q_last[35]); end
    checks++; if (st_seq.size() != 3 || st_seq[0] !== 6'd1 || st_seq[1] !== 6'd2 || st_seq[2] !== 6'd3) begin
      errors++; $display("FAIL basic_state_seq: size=%0d first=%0d want RUN,DRAIN,DONE (1,2,3)", st_seq.size(), st_seq[0]); end
    checks++; if (first_valid < 1 || first_valid > 2) begin
      errors++; $display("FAIL basic_first_latency: got %0d cycles want 1..2", first_valid); end
    checks++; if (S_OSHIFT !== 6'h15) begin
      errors++; $display("FAIL basic_oshift: got %h want 15", S_OSHIFT); end
    end_layer("basic");
  endtask

  task automatic test_padding();
    set_cfg(4, 4, 3, 1, 1, 1, 8);
    run_layer(0, 0);
    checks++; if (q_iaddr.size() != 144) begin errors++; $display("FAIL pad_count: got %0d want 144", q_iaddr.size()); end
    checks++; if (q_pad[0] !== 1'b1 || q_iaddr[0] !== 13'h000) begin
      errors++; $display("FAIL pad_beat0: pad=%b iaddr=%h want 1 000", q_pad[0], q_iaddr[0]); end
    checks++; if (q_pad[4] !== 1'b0 || q_iaddr[4] !== 13'h100) begin
      errors++; $display("FAIL pad_beat4: pad=%b iaddr=%h want 0 100", q_pad[4], q_iaddr[4]); end
    checks++; if (q_pad[143] !== 1'b1 || q_oaddr[143] !== 13'h30F) begin
      errors++; $display("FAIL pad_last: pad=%b oaddr=%h want 1 30f", q_pad[143], q_oaddr[143]); end
    end_layer("pad");
  endtask

  task automatic test_stride();
    set_cfg(5, 5, 3, 2, 0, 1, 8);
    run_layer(0, 0);
    checks++; if (q_iaddr.size() != 36) begin errors++; $display("FAIL stride_count: got %0d want 36", q_iaddr.size()); end
    checks++; if (q_iaddr[9] !== 13'h102 || q_first[9] !== 1'b1) begin
      errors++; $display("FAIL stride_beat9: iaddr=%h first=%b want 102 1", q_iaddr[9], q_first[9]); end
    checks++; if (q_iaddr[35] !== 13'h118 || q_oaddr[35] !== 13'h303) begin
      errors++; $display("FAIL stride_last: iaddr=%h oaddr=%h want 118 303", q_iaddr[35], q_oaddr[35]); end
    end_layer("stride");
  endtask

  task automatic test_backpressure_tiling();
    set_cfg(4, 4, 3, 1, 0, 2, 9);
    run_layer(1, 0);
    checks++; if (q_iaddr.size() != 144) begin errors++; $display("FAIL bp_count: got %0d want 144", q_iaddr.size()); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stall cycles want 0", unstable); end
    checks++; if (q_iaddr[1] !== 13'h101 || q_waddr[1] !== 13'h201) begin
      errors++; $display("FAIL bp_beat1: iaddr=%h waddr=%h want 101 201", q_iaddr[1], q_waddr[1]); end
    checks++; if (q_iaddr[17] !== 13'h115 || q_waddr[17] !== 13'h211 || q_last[17] !== 1'b1) begin
      errors++; $display("FAIL bp_beat17: iaddr=%h waddr=%h last=%b want 115 211 1", q_iaddr[17], q_waddr[17], q_last[17]); end
    checks++; if (q_waddr[72] !== 13'h212 || q_first[72] !== 1'b1 || q_oaddr[72] !== 13'h304) begin
      errors++; $display("FAIL tile2_beat0: waddr=%h first=%b oaddr=%h want 212 1 304", q_waddr[72], q_first[72], q_oaddr[72]); end
    checks++; if (q_oaddr[143] !== 13'h307) begin
      errors++; $display("FAIL tile2_last_oaddr: got %h want 307", q_oaddr[143]); end
    end_layer("bp");
  endtask

  task automatic test_illegal();
    set_cfg(4, 4, 3, 1, 0, 1, 8);
    WSIZE = 8'h03;
    run_layer(0, 0);
    checks++; if (STATE !== 6'd4 || end_cycles > 2) begin
      errors++; $display("FAIL illegal_err: STATE=%0d after %0d cycles want 4 within 2", STATE, end_cycles); end
    checks++; if (vcycles != 0) begin errors++; $display("FAIL illegal_novalid: %0d valid cycles want 0", vcycles); end
    repeat (3) @(negedge CLK);
    checks++; if (STATE !== 6'd4) begin errors++; $display("FAIL illegal_hold: STATE=%0d want 4", STATE); end
    end_layer("illegal");
    set_cfg(2, 2, 3, 1, 0, 1, 8);
    run_layer(0, 0);
    checks++; if (STATE !== 6'd4 || vcycles != 0) begin
      errors++; $display("FAIL illegal_k_gt_h: STATE=%0d valid=%0d want 4 0", STATE, vcycles); end
    end_layer("illegal2");
  endtask

  task automatic test_reset_restart();
    set_cfg(4, 4, 3, 1, 0, 1, 8);
    S_READY = 1'b1;
    EN = 1'b1;
    repeat (10) @(negedge CLK);
    checks++; if (STATE !== 6'd1 || S_VALID !== 1'b1) begin
      errors++; $display("FAIL rst_midrun_pre: STATE=%0d VALID=%b want 1 1", STATE, S_VALID); end
    RESET = 1'b1; EN = 1'b0;
    @(negedge CLK);
    checks++; if (STATE !== 6'd0 || S_VALID !== 1'b0) begin
      errors++; $display("FAIL rst_midrun: STATE=%0d VALID=%b want 0 0", STATE, S_VALID); end
    RESET = 1'b0;
    @(negedge CLK);
    run_layer(0, 0);
    checks++; if (q_iaddr.size() != 36 || q_iaddr[0] !== 13'h100 || q_first[0] !== 1'b1 || q_oaddr[35] !== 13'h303) begin
      errors++; $display("FAIL rst_restart: count=%0d iaddr0=%h oaddr35=%h want 36 100 303",
                         q_iaddr.size(), q_iaddr[0], q_oaddr[35]); end
    end_layer("restart");
  endtask

  task automatic test_drain_hold();
    set_cfg(4, 4, 3, 1, 0, 1, 8);
    ARRAY_IDLE = 1'b0;
    run_layer(0, 1);
    repeat (20) @(negedge CLK);
    checks++; if (STATE !== 6'd2 || S_VALID !== 1'b0 || q_iaddr.size() != 36) begin
      errors++; $display("FAIL drain_hold: STATE=%0d VALID=%b beats=%0d want 2 0 36", STATE, S_VALID, q_iaddr.size()); end
    ARRAY_IDLE = 1'b1;
    @(negedge CLK);
    checks++; if (STATE !== 6'd3) begin errors++; $display("FAIL drain_release: STATE=%0d want 3", STATE); end
    end_layer("drain");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_padding();
    test_stride();
    test_backpressure_tiling();
    test_illegal();
    test_reset_restart();
    test_drain_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
